// File: rtl/updown_mod_counter.sv
// One mod-(MAX+1) digit with up/down, clamped parallel load and wrap/saturate mode.
// BORROW/CARRY are combinational so a chained digit ticks on the same clock edge.
module updown_mod_counter #(
    parameter int unsigned WIDTH            = 4,
    parameter bit          SATURATE_DEFAULT = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             TICK,
    input  logic             DIR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    input  logic [WIDTH-1:0] MAX,
    input  logic             SAT_SET,
    input  logic             SAT_IN,
    output logic [WIDTH-1:0] COUNT,
    output logic             BORROW,
    output logic             CARRY,
    output logic             AT_ZERO,
    output logic             AT_MAX,
    output logic             SAT_MODE
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             use_max_q, use_max_d;
    logic             sat_q, sat_d;
    logic             wrap_en;

    // Reset value is the runtime MAX input, so instead of an asynchronous load
    // the digit presents MAX until the first clock edge captures it.
    assign COUNT    = use_max_q ? MAX : count_q;
    assign AT_ZERO  = (COUNT == '0);
    assign AT_MAX   = (COUNT == MAX);
    assign SAT_MODE = sat_q;

    assign wrap_en = ~CLR & CE & TICK & ~LOAD & ~sat_q;
    assign BORROW  = wrap_en & ~DIR & AT_ZERO;
    assign CARRY   = wrap_en & DIR & AT_MAX;

    always_comb begin
        count_d   = COUNT;
        use_max_d = 1'b0;
        sat_d     = sat_q;
        if (CE) begin
            if (SAT_SET) begin
                sat_d = SAT_IN;
            end
            if (LOAD) begin
                count_d = (LOAD_VALUE > MAX) ? MAX : LOAD_VALUE;
            end else if (TICK) begin
                if (COUNT > MAX) begin
                    count_d = MAX;
                end else if (DIR) begin
                    if (AT_MAX) begin
                        count_d = sat_q ? MAX : '0;
                    end else begin
                        count_d = COUNT + WIDTH'(1);
                    end
                end else begin
                    if (AT_ZERO) begin
                        count_d = sat_q ? '0 : MAX;
                    end else begin
                        count_d = COUNT - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            count_q   <= '0;
            use_max_q <= 1'b1;
            sat_q     <= SATURATE_DEFAULT;
        end else begin
            count_q   <= count_d;
            use_max_q <= use_max_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Table-driven bench with a scoreboard queue; a second instance is chained from CARRY.
module tb_updown_mod_counter;

    typedef struct {
        logic       ce, tick, dir, load;
        logic [3:0] lv, mx;
        logic       sset, sin;
        logic [3:0] exp_cnt;
        logic       exp_b, exp_c, exp_sat;
        string      name;
    } vec_t;

    logic       clk, clr, ce, tick, dir, load, sset, sin;
    logic [3:0] lv, mx, cnt;
    logic       borrow, carry, az, am, sat;

    logic       hi_load;
    logic [3:0] hi_lv, hi_mx, hi_cnt;
    logic       hi_b, hi_c, hi_az, hi_am, hi_sat;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    updown_mod_counter #(.WIDTH(4), .SATURATE_DEFAULT(1'b0)) u_lo (
        .CLK(clk), .CLR(clr), .CE(ce), .TICK(tick), .DIR(dir), .LOAD(load),
        .LOAD_VALUE(lv), .MAX(mx), .SAT_SET(sset), .SAT_IN(sin),
        .COUNT(cnt), .BORROW(borrow), .CARRY(carry), .AT_ZERO(az), .AT_MAX(am),
        .SAT_MODE(sat)
    );

    updown_mod_counter #(.WIDTH(4), .SATURATE_DEFAULT(1'b0)) u_hi (
        .CLK(clk), .CLR(clr), .CE(1'b1), .TICK(carry), .DIR(1'b1), .LOAD(hi_load),
        .LOAD_VALUE(hi_lv), .MAX(hi_mx), .SAT_SET(1'b0), .SAT_IN(1'b0),
        .COUNT(hi_cnt), .BORROW(hi_b), .CARRY(hi_c), .AT_ZERO(hi_az), .AT_MAX(hi_am),
        .SAT_MODE(hi_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic c, input logic t, input logic d, input logic l,
                                 input logic [3:0] v, input logic [3:0] m,
                                 input logic ss, input logic si, input logic [3:0] ec,
                                 input logic eb, input logic ecy, input logic es,
                                 input string n);
        vec_t r;
        r.ce = c; r.tick = t; r.dir = d; r.load = l; r.lv = v; r.mx = m;
        r.sset = ss; r.sin = si; r.exp_cnt = ec; r.exp_b = eb; r.exp_c = ecy;
        r.exp_sat = es; r.name = n;
        return r;
    endfunction

    // Drive at negedge, check combinational flags, then compare registered state after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        ce = v.ce; tick = v.tick; dir = v.dir; load = v.load; lv = v.lv; mx = v.mx;
        sset = v.sset; sin = v.sin;
        #1;
        chk({v.name, ".borrow"}, borrow, v.exp_b);
        chk({v.name, ".carry"}, carry, v.exp_c);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({v.name, ".sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({e.name, ".count"}, cnt, e.exp_cnt);
            chk({e.name, ".sat"}, sat, e.exp_sat);
            chk({e.name, ".at_zero"}, az, (e.exp_cnt == 4'd0));
            chk({e.name, ".at_max"}, am, (e.exp_cnt == e.mx));
        end
    endtask

    initial begin
        clr = 1'b1; ce = 1'b0; tick = 1'b0; dir = 1'b0; load = 1'b0;
        lv = 4'd0; mx = 4'd9; sset = 1'b0; sin = 1'b0;
        hi_load = 1'b0; hi_lv = 4'd0; hi_mx = 4'd5;

        //        ce tk dr ld lv     mx    ss si exp    b  c  sat
        vecs.push_back(mkv(1,0,0,1, 4'd3, 4'd9, 0,0, 4'd3, 0,0,0, "load3"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd2, 0,0,0, "dn_a"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd1, 0,0,0, "dn_b"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd0, 0,0,0, "dn_c"));
        vecs.push_back(mkv(1,1,0,1, 4'd12,4'd9, 0,0, 4'd9, 0,0,0, "load12_clamp"));
        for (int i = 8; i >= 0; i--)
            vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'(i), 0,0,0, "dn_run"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd9, 1,0,0, "dn_wrap"));
        vecs.push_back(mkv(1,0,0,1, 4'd0, 4'd5, 0,0, 4'd0, 0,0,0, "load0_m5"));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd5, 0,0, 4'(i), 0,0,0, "up_run"));
        vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd5, 0,0, 4'd0, 0,1,0, "up_wrap"));
        vecs.push_back(mkv(1,0,0,1, 4'd1, 4'd9, 1,1, 4'd1, 0,0,1, "sat_on"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd0, 0,0,1, "sat_dn1"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd0, 0,0,1, "sat_dn2"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd9, 0,0, 4'd0, 0,0,1, "sat_dn3"));
        vecs.push_back(mkv(1,0,0,1, 4'd9, 4'd9, 0,0, 4'd9, 0,0,1, "load9"));
        vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd9, 0,0, 4'd9, 0,0,1, "sat_up1"));
        vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd9, 0,0, 4'd9, 0,0,1, "sat_up2"));
        vecs.push_back(mkv(1,0,0,0, 4'd0, 4'd9, 1,0, 4'd9, 0,0,0, "sat_off"));
        vecs.push_back(mkv(0,1,1,0, 4'd0, 4'd9, 1,1, 4'd9, 0,0,0, "ce0_satset"));
        vecs.push_back(mkv(1,0,0,1, 4'd7, 4'd9, 0,0, 4'd7, 0,0,0, "load7"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd5, 0,0, 4'd5, 0,0,0, "oor_dn"));
        vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd5, 0,0, 4'd0, 0,1,0, "wrap_m5"));
        vecs.push_back(mkv(0,1,0,0, 4'd0, 4'd5, 0,0, 4'd0, 0,0,0, "ce0_dn"));
        vecs.push_back(mkv(0,1,1,0, 4'd0, 4'd5, 0,0, 4'd0, 0,0,0, "ce0_up"));
        vecs.push_back(mkv(1,0,0,1, 4'd4, 4'd0, 0,0, 4'd0, 0,0,0, "load_m0"));
        vecs.push_back(mkv(1,1,0,0, 4'd0, 4'd0, 0,0, 4'd0, 1,0,0, "m0_dn"));
        vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd0, 0,0, 4'd0, 0,1,0, "m0_up"));
        vecs.push_back(mkv(1,0,0,1, 4'd8, 4'd9, 0,0, 4'd8, 0,0,0, "load8"));
        vecs.push_back(mkv(1,1,1,0, 4'd0, 4'd3, 0,0, 4'd3, 0,0,0, "oor_up"));
        vecs.push_back(mkv(1,0,0,0, 4'd0, 4'd3, 1,1, 4'd3, 0,0,1, "sat_on2"));

        repeat (2) @(negedge clk);
        chk("rst.count", cnt, 4'd9);
        chk("rst.sat", sat, 1'b0);
        chk("rst.at_max", am, 1'b1);
        clr = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Mid-cycle reset: COUNT must jump to MAX before any edge, flags suppressed.
        @(negedge clk);
        mx = 4'd9; ce = 1'b1; tick = 1'b1; dir = 1'b1; load = 1'b0; sset = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("clr.count", cnt, 4'd9);
        chk("clr.carry", carry, 1'b0);
        chk("clr.borrow", borrow, 1'b0);
        chk("clr.sat", sat, 1'b0);
        #1 clr = 1'b0; tick = 1'b0;
        @(posedge clk);
        #1 chk("clr.hold", cnt, 4'd9);

        // Chained digits: 0:0 -> 0:5 -> 1:0 with the high digit ticking off CARRY.
        hi_load = 1'b1; hi_lv = 4'd0;
        step(mkv(1,0,0,1, 4'd0, 4'd5, 0,0, 4'd0, 0,0,0, "chain_load"));
        hi_load = 1'b0;
        chk("chain.hi_init", hi_cnt, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            step(mkv(1,1,1,0, 4'd0, 4'd5, 0,0, 4'((i == 6) ? 0 : i), 0, (i == 6), 0, "chain_up"));
            chk("chain.hi", hi_cnt, (i == 6) ? 4'd1 : 4'd0);
        end

        if (exp_q.size() != 0) chk("sb.leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the chess-clock digit counter: one mod-(MAX+1) digit, generalised in width.
- Adds runtime up/down direction, synchronous parallel load, and a wrap or saturate mode.
- Provides combinational borrow/carry outputs so digits chain ripple-free: the next digit ticks on the same edge.
- Used for seconds/minutes digits of each player's clock and for the increment/time-setting menu.

Parameters:
- WIDTH, 4, bit width of COUNT, MAX and LOAD_VALUE.
- SATURATE_DEFAULT, 0, value of the saturate mode after reset (0 = wrap, 1 = saturate).

Ports:
- CLK  in  1  system clock, all state changes on rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; when 0, COUNT holds and BORROW/CARRY are 0.
- TICK  in  1  count request, one-cycle pulse or level (one step per enabled cycle).
- DIR  in  1  0 = count down, 1 = count up.
- LOAD  in  1  synchronous parallel load request.
- LOAD_VALUE  in  WIDTH  value for LOAD.
- MAX  in  WIDTH  top value of the digit; the digit runs over 0..MAX.
- SAT_SET  in  1  on an enabled cycle, latches SAT_IN into the mode register.
- SAT_IN  in  1  new mode value (1 = saturate).
- COUNT  out  WIDTH  current digit value (registered).
- BORROW  out  1  combinational; down-wrap event this cycle.
- CARRY  out  1  combinational; up-wrap event this cycle.
- AT_ZERO  out  1  combinational; COUNT == 0.
- AT_MAX  out  1  combinational; COUNT == MAX.
- SAT_MODE  out  1  current mode register.

Behaviour:
- Reset:
  - CLR high → COUNT = MAX (sampled asynchronously, like the existing digit) and SAT_MODE = SATURATE_DEFAULT.
  - BORROW and CARRY are 0 while CLR is high.
  - Reset mid-count aborts immediately; there is no pending state.
- All synchronous actions require CE = 1. Priority per cycle, highest first: LOAD, then TICK. SAT_SET is independent and takes effect from the next cycle.
- Load:
  - COUNT ← LOAD_VALUE if LOAD_VALUE ≤ MAX, else COUNT ← MAX (clamp).
  - A simultaneous TICK is ignored and no BORROW/CARRY is produced.
- Down tick (DIR = 0):
  - COUNT > 0 and COUNT ≤ MAX → COUNT − 1.
  - COUNT == 0, wrap mode → COUNT ← MAX.
  - COUNT == 0, saturate mode → COUNT holds 0.
- Up tick (DIR = 1):
  - COUNT < MAX → COUNT + 1.
  - COUNT == MAX, wrap mode → COUNT ← 0.
  - COUNT == MAX, saturate mode → holds MAX.
- Out of range: if COUNT > MAX (MAX lowered at runtime), any tick sets COUNT ← MAX. No borrow or carry is generated for this correction.
- BORROW = CE & TICK & ~LOAD & ~DIR & (COUNT == 0) & ~SAT_MODE.
- CARRY = CE & TICK & ~LOAD & DIR & (COUNT == MAX) & ~SAT_MODE.
- BORROW and CARRY are never asserted together. They are asserted in the same cycle as the wrap, so the next digit's TICK is driven directly from them.
- Arithmetic is WIDTH-bit unsigned with no intermediate overflow. MAX = 0 is legal: the digit stays 0, and in wrap mode every tick is a BORROW or CARRY.
- Latency: COUNT updates at the edge after TICK/LOAD is sampled. Flags follow COUNT combinationally.

Test Plan:
- WIDTH=4, MAX=9, CLR pulse → COUNT=9 asynchronously before the next CLK edge; SAT_MODE=0.
- MAX=9, DIR=0, wrap, 10 enabled ticks → 8,7,…,0, then the 10th tick gives COUNT=9 with BORROW=1 for exactly that cycle; AT_ZERO=1 while COUNT=0.
- MAX=5, DIR=1, wrap, from 0 apply 6 ticks → 1..5, then 0 with CARRY=1 on the 6th tick. Two chained instances (CARRY→TICK) count 0:0 → 0:5 → 1:0.
- SAT_SET with SAT_IN=1, DIR=0 from COUNT=1, 3 ticks → 0,0,0 with BORROW never asserted. Same test with DIR=1 at MAX=9 holds 9 with no CARRY.
- LOAD=1, LOAD_VALUE=12, MAX=9, with TICK=1 → COUNT=9 and no BORROW. LOAD_VALUE=3 → COUNT=3.
- COUNT=7, MAX changed to 5, one down tick → COUNT=5 and no BORROW. With CE=0, ticks leave COUNT unchanged and BORROW/CARRY stay 0.
